// File: rtl/shift_add_mul_ctrl_pkg.sv
// Shared constants and FSM encoding for the shift-and-add multiplier.
// Imported by the interface, the adder and the control module.
package shift_add_mul_ctrl_pkg;

    localparam int MUL_WIDTH = 16;
    localparam int MUL_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_e;

endpackage

// File: rtl/shift_add_mul_ctrl_if.sv
// Request/result bundle between the CPU and the multi-cycle MUL unit.
// The master side issues operands; the slave side returns the product.
interface shift_add_mul_ctrl_if;
    import shift_add_mul_ctrl_pkg::*;

    logic                     start;
    logic [MUL_WIDTH-1:0]     a;
    logic [MUL_WIDTH-1:0]     b;
    logic                     busy;
    logic                     done;
    logic [2*MUL_WIDTH-1:0]   product;

    modport master (
        output start, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, a, b,
        output busy, done, product
    );

endinterface

// File: rtl/shift_add_mul_ctrl_rca.sv
// 16-bit ripple-carry adder shared with the multiplier datapath.
// Carry ripples bit by bit; no lookahead.
module shift_add_mul_ctrl_rca
    import shift_add_mul_ctrl_pkg::*;
(
    input  logic [MUL_WIDTH-1:0] a,
    input  logic [MUL_WIDTH-1:0] b,
    input  logic                 cin,
    output logic [MUL_WIDTH-1:0] sum,
    output logic                 cout
);

    logic [MUL_WIDTH:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < MUL_WIDTH; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[MUL_WIDTH];
    end

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Multi-cycle unsigned 16x16->32 MUL unit: one shift-and-add step per clock
// through a single shared ripple-carry adder.
module shift_add_mul_ctrl
    import shift_add_mul_ctrl_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    shift_add_mul_ctrl_if.slave bus
);

    state_e state, nxt;

    logic [WIDTH-1:0]   m, p, q;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] prod_q;

    logic [WIDTH-1:0] opb, sum;
    logic             cout;
    logic             accept, run, last;

    assign accept = (state == ST_IDLE) && bus.start;
    assign run    = (state == ST_RUN);
    assign last   = run && (count == CNT_W'(WIDTH - 1));

    // Partial product is only added when the current multiplier bit is set
    assign opb = q[0] ? m : '0;

    shift_add_mul_ctrl_rca u_rca (
        .a    (p),
        .b    (opb),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: if (bus.start) nxt = ST_RUN;
            ST_RUN:  if (last)      nxt = ST_DONE;
            ST_DONE:                nxt = ST_IDLE;
            default:                nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m      <= '0;
            p      <= '0;
            q      <= '0;
            count  <= '0;
            prod_q <= '0;
        end else begin
            unique case (1'b1)
                accept: begin
                    m     <= bus.a;
                    p     <= '0;
                    q     <= bus.b;
                    count <= '0;
                end
                run: begin
                    // Carry-out lands in p's MSB so nothing is lost on the shift
                    {p, q} <= {cout, sum, q[WIDTH-1:1]};
                    count  <= count + 1'b1;
                    if (last) prod_q <= {cout, sum, q[WIDTH-1:1]};
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = (state == ST_RUN) || (state == ST_DONE);
    assign bus.done    = (state == ST_DONE);
    assign bus.product = prod_q;

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Directed bench for the shift-and-add MUL unit with a cycle-level
// reference model (a*b, 17 busy cycles, done on the last).
module tb_shift_add_mul_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    shift_add_mul_ctrl_if bus ();

    shift_add_mul_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic check(input string nm, input logic [33:0] act,
                         input logic [33:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: busy for 17 cycles after an accept, done and the
    // product appear together on the last of them.
    int          mcnt;
    logic [31:0] mpend;
    logic [31:0] mprod;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt  <= 0;
            mpend <= '0;
            mprod <= '0;
        end else if (mcnt == 0) begin
            if (bus.start) begin
                mcnt  <= 17;
                mpend <= {16'h0, bus.a} * {16'h0, bus.b};
            end
        end else begin
            mcnt <= mcnt - 1;
            if (mcnt == 2) mprod <= mpend;
        end
    end

    always @(negedge clk) begin
        if (!rst)
            check("cycle", {bus.busy, bus.done, bus.product},
                  {mcnt != 0, mcnt == 1, mprod});
    end

    task automatic run_op(input logic [15:0] x, input logic [15:0] y,
                          input logic [31:0] exp, input string nm);
        int nb;
        nb = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~x;
        bus.b     = ~y;
        for (int n = 0; n < 40; n++) begin
            if (bus.busy) nb++;
            if (bus.done) break;
            @(negedge clk);
        end
        check({nm, "_done"}, {33'h0, bus.done}, 34'h1);
        check({nm, "_prod"}, {2'b0, bus.product}, {2'b0, exp});
        check({nm, "_busy"}, 34'(nb), 34'd17);
    endtask

    initial begin
        int nd;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(negedge clk);
        check("reset", {bus.busy, bus.done, bus.product}, 34'h0);
        #1 rst = 1'b0;

        run_op(16'd3, 16'd5, 32'h0000000F, "t1");
        run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "t2");
        run_op(16'h0000, 16'h1234, 32'h00000000, "t3a");
        run_op(16'h1234, 16'h0001, 32'h00001234, "t3b");

        // start held high, operands changed during RUN
        nd = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'd5;
        bus.b     = 16'd6;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            if (i == 5)  begin bus.a = 16'd7; bus.b = 16'd7; end
            if (i == 25) begin bus.a = 16'd9; bus.b = 16'd9; end
            if (bus.done) nd++;
            if (i == 17) check("t4_first", {2'b0, bus.product}, 34'd30);
            if (i == 35) check("t4_second", {2'b0, bus.product}, 34'd49);
        end
        bus.start = 1'b0;
        check("t4_count", 34'(nd), 34'd2);
        @(negedge clk);
        @(negedge clk);

        // async reset in the middle of RUN
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'd11;
        bus.b     = 16'd13;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst = 1'b1;
        #1 check("t5_rst", {bus.busy, bus.done, bus.product}, 34'h0);
        @(negedge clk);
        #1 rst = 1'b0;
        run_op(16'd7, 16'd9, 32'd63, "t5");

        run_op(16'h8000, 16'h0002, 32'h00010000, "t6a");
        run_op(16'h00FF, 16'h0101, 32'h0000FFFF, "t6b");

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
